// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the TX frame block and the future RX frame block.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
        logic result;
        case (mode)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~^data;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame_baud_gen.sv
// One-cycle baud tick generator: counts 0..div and ticks on the terminal count.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign tick = (cnt_q == div);

    // Next count: restart at frame accept, wrap after the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = {DIV_WIDTH{1'b0}};
        end else if (tick) begin
            cnt_d = {DIV_WIDTH{1'b0}};
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1'b1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= {DIV_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// one or two stop bits, each bit held for clock_div+1 system clocks.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] clock_div,
    uart_tx_frame_if.slave       bus,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic TWO_STOP = (STOP_BITS == 2);
    localparam uart_pkg::parity_e PAR_MODE = (PARITY == 1) ? uart_pkg::PAR_ODD  :
                                             (PARITY == 2) ? uart_pkg::PAR_EVEN :
                                                             uart_pkg::PAR_NONE;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_pkg::tx_state_e  state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0] div_q,   div_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic                 par_q,   par_d;
    logic                 stop_q,  stop_d;
    logic                 tx_q,    tx_d;
    logic                 busy_q,  busy_d;
    logic                 done_s;
    logic                 accept_s;
    logic                 tick_s;

    assign bus.tx_ready = (state_q == uart_pkg::IDLE);
    assign accept_s     = bus.tx_valid && bus.tx_ready;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .restart (accept_s),
        .div     (div_q),
        .tick    (tick_s)
    );

    // Next-state, datapath updates and end-of-frame pulse; everything advances only on a tick.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        idx_d   = idx_q;
        par_d   = par_q;
        stop_d  = stop_q;
        done_s  = 1'b0;
        case (state_q)
            uart_pkg::IDLE: begin
                if (accept_s) begin
                    state_d = uart_pkg::START;
                    shift_d = bus.tx_data;
                    div_d   = clock_div;
                    par_d   = uart_pkg::calc_parity(9'(bus.tx_data), PAR_MODE);
                    idx_d   = {IDX_W{1'b0}};
                    stop_d  = 1'b0;
                end else begin
                    state_d = uart_pkg::IDLE;
                end
            end
            uart_pkg::START: begin
                if (tick_s) begin
                    state_d = uart_pkg::DATA;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = uart_pkg::START;
                end
            end
            uart_pkg::DATA: begin
                if (tick_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PAR_MODE != uart_pkg::PAR_NONE) ? uart_pkg::PARITY
                                                                   : uart_pkg::STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1'b1);
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end else begin
                    state_d = uart_pkg::DATA;
                end
            end
            uart_pkg::PARITY: begin
                if (tick_s) begin
                    state_d = uart_pkg::STOP;
                    stop_d  = 1'b0;
                end else begin
                    state_d = uart_pkg::PARITY;
                end
            end
            uart_pkg::STOP: begin
                if (tick_s) begin
                    if (TWO_STOP && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = uart_pkg::IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_d = uart_pkg::STOP;
                end
            end
            default: begin
                state_d = uart_pkg::IDLE;
            end
        endcase
    end

    // Line level is registered from the state being entered, so tx changes with the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != uart_pkg::IDLE);
        case (state_d)
            uart_pkg::START:  tx_d = 1'b0;
            uart_pkg::DATA:   tx_d = shift_d[0];
            uart_pkg::PARITY: tx_d = par_q;
            default:          tx_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= uart_pkg::IDLE;
            shift_q <= {DATA_BITS{1'b0}};
            div_q   <= {DIV_WIDTH{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_s & ~reset;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7E2, 8O1) checked cycle by cycle.
module tb_uart_tx_frame;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cdiv;
    logic [8:0]  data;
    logic        valid;
    logic [1:0]  sel;

    always #5 clock = ~clock;

    uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(7)) if_b ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_c ();

    assign if_a.tx_valid = valid && (sel == 2'd0);
    assign if_b.tx_valid = valid && (sel == 2'd1);
    assign if_c.tx_valid = valid && (sel == 2'd2);
    assign if_a.tx_data  = data[7:0];
    assign if_b.tx_data  = data[6:0];
    assign if_c.tx_data  = data[7:0];

    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) u_a (
        .clock(clock), .reset(reset), .clock_div(cdiv), .bus(if_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));
    uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DIV_WIDTH(16)) u_b (
        .clock(clock), .reset(reset), .clock_div(cdiv), .bus(if_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_WIDTH(16)) u_c (
        .clock(clock), .reset(reset), .clock_div(cdiv), .bus(if_c),
        .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

    logic tx_m, done_m, ready_m, busy_m;
    always_comb begin
        case (sel)
            2'd1:    {tx_m, done_m, ready_m, busy_m} = {tx_b, done_b, if_b.tx_ready, busy_b};
            2'd2:    {tx_m, done_m, ready_m, busy_m} = {tx_c, done_c, if_c.tx_ready, busy_c};
            default: {tx_m, done_m, ready_m, busy_m} = {tx_a, done_a, if_a.tx_ready, busy_a};
        endcase
    end

    typedef struct packed {
        logic tx;
        logic done;
        logic ready;
        logic busy;
    } exp_t;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] div;
        logic [8:0]  data;
        int          nbits;
        logic [12:0] frame;   // line levels in send order, bit 0 = start bit
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   vectors     = 0;
    int   miscompares = 0;

    // Scoreboard consumer: one expected record per clock, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if ({tx_m, done_m, ready_m, busy_m} !== e) begin
                    miscompares++;
                    $display("FAIL frame_cycle sel=%0d t=%0t got tx/done/ready/busy=%b%b%b%b want %b%b%b%b",
                             sel, $time, tx_m, done_m, ready_m, busy_m, e.tx, e.done, e.ready, e.busy);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [1:0] s, input logic [15:0] dv, input logic [8:0] d,
                        input int nbits, input logic [12:0] frame, input bit keep, input bit push);
        logic r;
        bit   accepted;
        int   cyc;
        sel      = s;
        cdiv     = dv;
        data     = d;
        valid    = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(negedge clock);
            r = ready_m;
            @(posedge clock);
            accepted = r;
        end
        #1;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout sel=%0d got no tx_ready want tx_ready=1", s);
            valid = 1'b0;
        end else begin
            if (!keep) valid = 1'b0;
            if (push) begin
                cyc = int'(dv) + 1;
                for (int b = 0; b < nbits; b++) begin
                    for (int c = 0; c < cyc; c++) begin
                        exp_q.push_back(exp_t'({frame[b], (b == nbits - 1) && (c == cyc - 1), 1'b0, 1'b1}));
                    end
                end
                exp_q.push_back(exp_t'({1'b1, 1'b0, 1'b1, 1'b0}));
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        vecs[0] = '{2'd0, 16'd3, 9'h0A5, 10, 13'(10'b1101001010)};
        vecs[1] = '{2'd1, 16'd3, 9'h055, 11, 13'(11'b11010101010)};
        vecs[2] = '{2'd2, 16'd3, 9'h0FF, 11, 13'(11'b11111111110)};
        vecs[3] = '{2'd2, 16'd3, 9'h000, 11, 13'(11'b11000000000)};
        vecs[4] = '{2'd0, 16'd1, 9'h03C, 10, 13'(10'b1001111000)};
        vecs[5] = '{2'd1, 16'd0, 9'h07F, 11, 13'(11'b11111111110)};
        vecs[6] = '{2'd0, 16'd2, 9'h080, 10, 13'(10'b1100000000)};

        reset = 1'b1;
        valid = 1'b0;
        sel   = 2'd0;
        data  = 9'h000;
        cdiv  = 16'd3;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_a", {28'd0, tx_a, busy_a, done_a, if_a.tx_ready}, 32'h9);
        chk("reset_b", {28'd0, tx_b, busy_b, done_b, if_b.tx_ready}, 32'h9);
        chk("reset_c", {28'd0, tx_c, busy_c, done_c, if_c.tx_ready}, 32'h9);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].sel, vecs[v].div, vecs[v].data, vecs[v].nbits, vecs[v].frame, 1'b0, 1'b1);
            drain();
        end

        // Back-to-back with tx_valid held: word changes mid-frame must not disturb frame 1.
        send(2'd0, 16'd1, 9'h001, 10, 13'(10'b1000000010), 1'b1, 1'b1);
        data = 9'h002;
        send(2'd0, 16'd1, 9'h002, 10, 13'(10'b1000000100), 1'b0, 1'b1);
        drain();

        // Divider change mid-frame takes effect only on the next frame.
        send(2'd0, 16'd0, 9'h0A5, 10, 13'(10'b1101001010), 1'b0, 1'b1);
        cdiv = 16'd9;
        drain();
        send(2'd0, 16'd9, 9'h05A, 10, 13'(10'b1010110100), 1'b0, 1'b1);
        drain();

        // Reset during data bit 3 aborts the frame without a done pulse.
        send(2'd0, 16'd3, 9'h0A5, 10, 13'(10'b1101001010), 1'b0, 1'b0);
        repeat (17) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_bit3_level", {31'd0, tx_a}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_state", {28'd0, tx_a, busy_a, done_a, if_a.tx_ready}, 32'h9);
        begin
            logic seen_done;
            seen_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                seen_done = seen_done | done_a | ~tx_a;
            end
            chk("abort_quiet_line", {31'd0, seen_done}, 32'h0);
        end
        @(posedge clock);
        #1;
        send(2'd0, 16'd3, 9'h0A5, 10, 13'(10'b1101001010), 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
